// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants, the EX/MEM and MEM/WB register layouts,
// and the store lane-select helper.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic [1:0]            size;
    logic                  is_unsigned;
  } ex_mem_t;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [REG_ADDR_W-1:0] addr;
    logic                  en;
    logic                  misaligned;
  } mem_wb_t;

  // Big-endian lanes: byte offset 0 maps to be[3] (bits 31:24).
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      MEM_BYTE: be = 4'b1000 >> off;
      MEM_HALF: be = off[1] ? 4'b0011 : 4'b1100;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory: byte-enable synchronous write and
// asynchronous read.
module data_memory
   import mips_pkg::*;
#(
   parameter int    DEPTH     = 1024,
   parameter int    ADDR_W    = 10,
   parameter string INIT_FILE = ""
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [3:0]        i_be,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/memory_access_top.sv
// MEM stage: EX/MEM register, data memory access with lane select and
// alignment checking, and the MEM/WB register feeding register write-back.
module memory_access_top
  import mips_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_W-1:0]     i_alu_result,
  input  logic [DATA_W-1:0]     i_store_data,
  input  logic [REG_ADDR_W-1:0] i_dest_addr,
  input  logic                  i_reg_write,
  input  logic                  i_mem_to_reg,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [1:0]            i_mem_size,
  input  logic                  i_mem_unsigned,
  input  logic                  i_stall,
  input  logic                  i_flush,
  output logic [DATA_W-1:0]     o_wb_data,
  output logic [REG_ADDR_W-1:0] o_wb_addr,
  output logic                  o_wb_en,
  output logic [DATA_W-1:0]     o_fwd_data,
  output logic [REG_ADDR_W-1:0] o_fwd_addr,
  output logic                  o_fwd_en,
  output logic                  o_misaligned
);

  ex_mem_t ex_mem_d, ex_mem_q;
  mem_wb_t mem_wb_d, mem_wb_q;
  mem_wb_t wb_next;

  logic [1:0]        off;
  logic              is_byte, is_half, is_word;
  logic              is_load, fault;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [7:0]        byte_val;
  logic [15:0]       half_val;
  logic [DATA_W-1:0] load_data;

  // Flush takes priority over stall so a squashed instruction never lingers.
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (i_flush) begin
      ex_mem_d = '0;
    end else if (!i_stall) begin
      ex_mem_d.alu         = i_alu_result;
      ex_mem_d.store_data  = i_store_data;
      ex_mem_d.dest        = i_dest_addr;
      ex_mem_d.reg_write   = i_reg_write;
      ex_mem_d.mem_to_reg  = i_mem_to_reg;
      ex_mem_d.mem_read    = i_mem_read;
      ex_mem_d.mem_write   = i_mem_write;
      ex_mem_d.size        = i_mem_size;
      ex_mem_d.is_unsigned = i_mem_unsigned;
    end
  end

  always_comb begin
    off     = ex_mem_q.alu[1:0];
    is_byte = (ex_mem_q.size == MEM_BYTE);
    is_half = (ex_mem_q.size == MEM_HALF);
    is_word = !is_byte && !is_half;
    is_load = ex_mem_q.mem_read && !ex_mem_q.mem_write;
    fault   = (ex_mem_q.mem_read || ex_mem_q.mem_write) &&
              ((is_half && off[0]) || (is_word && (off != 2'b00)));
  end

  // Store data is replicated across lanes; the byte enables pick the target.
  always_comb begin
    mem_be    = store_be(ex_mem_q.size, off);
    mem_wdata = is_byte ? {4{ex_mem_q.store_data[7:0]}} :
                is_half ? {2{ex_mem_q.store_data[15:0]}} :
                          ex_mem_q.store_data;
    mem_we    = ex_mem_q.mem_write && !fault && !i_stall;
  end

  data_memory #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_dmem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_be    (mem_be),
    .i_addr  (ex_mem_q.alu[ADDR_W+1:2]),
    .i_wdata (mem_wdata),
    .o_rdata (mem_rdata)
  );

  always_comb begin
    case (off)
      2'd0:    byte_val = mem_rdata[31:24];
      2'd1:    byte_val = mem_rdata[23:16];
      2'd2:    byte_val = mem_rdata[15:8];
      default: byte_val = mem_rdata[7:0];
    endcase
    half_val = off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    if (is_byte)
      load_data = ex_mem_q.is_unsigned ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
    else if (is_half)
      load_data = ex_mem_q.is_unsigned ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
    else
      load_data = mem_rdata;
  end

  always_comb begin
    wb_next.addr       = ex_mem_q.dest;
    wb_next.misaligned = fault;
    if (ex_mem_q.mem_to_reg)
      wb_next.data = (is_load && !fault) ? load_data : '0;
    else
      wb_next.data = (is_load && fault) ? '0 : ex_mem_q.alu;
    wb_next.en = ex_mem_q.reg_write && !fault && (ex_mem_q.dest != '0) &&
                 !(ex_mem_q.mem_read && ex_mem_q.mem_write);
    mem_wb_d = i_stall ? mem_wb_q : wb_next;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign o_wb_data    = mem_wb_q.data;
  assign o_wb_addr    = mem_wb_q.addr;
  assign o_wb_en      = mem_wb_q.en;
  assign o_misaligned = mem_wb_q.misaligned;
  assign o_fwd_data   = ex_mem_q.alu;
  assign o_fwd_addr   = ex_mem_q.dest;
  assign o_fwd_en     = ex_mem_q.reg_write && !ex_mem_q.mem_read;

endmodule

// File: tb/tb_memory_access_top.sv
// Directed bench for the MEM stage: loads/stores, lanes, alignment,
// stall/flush, forwarding and asynchronous reset.
module tb_memory_access_top;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_alu_result = '0;
  logic [31:0] i_store_data = '0;
  logic [4:0]  i_dest_addr = '0;
  logic        i_reg_write = 1'b0;
  logic        i_mem_to_reg = 1'b0;
  logic        i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0;
  logic [1:0]  i_mem_size = 2'b00;
  logic        i_mem_unsigned = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_addr;
  logic        o_wb_en;
  logic [31:0] o_fwd_data;
  logic [4:0]  o_fwd_addr;
  logic        o_fwd_en;
  logic        o_misaligned;

  int total = 0;
  int passed = 0;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  memory_access_top dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_alu_result   (i_alu_result),
    .i_store_data   (i_store_data),
    .i_dest_addr    (i_dest_addr),
    .i_reg_write    (i_reg_write),
    .i_mem_to_reg   (i_mem_to_reg),
    .i_mem_read     (i_mem_read),
    .i_mem_write    (i_mem_write),
    .i_mem_size     (i_mem_size),
    .i_mem_unsigned (i_mem_unsigned),
    .i_stall        (i_stall),
    .i_flush        (i_flush),
    .o_wb_data      (o_wb_data),
    .o_wb_addr      (o_wb_addr),
    .o_wb_en        (o_wb_en),
    .o_fwd_data     (o_fwd_data),
    .o_fwd_addr     (o_fwd_addr),
    .o_fwd_en       (o_fwd_en),
    .o_misaligned   (o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dest,
                        input logic rw, input logic m2r, input logic mr, input logic mw,
                        input logic [1:0] sz, input logic uns);
    i_alu_result   = alu;
    i_store_data   = sd;
    i_dest_addr    = dest;
    i_reg_write    = rw;
    i_mem_to_reg   = m2r;
    i_mem_read     = mr;
    i_mem_write    = mw;
    i_mem_size     = sz;
    i_mem_unsigned = uns;
  endtask

  task automatic set_idle();
    set_in(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, SZ_B, 1'b0);
  endtask

  // Issue one instruction, follow with a bubble; result is then in MEM/WB.
  task automatic run(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dest,
                     input logic rw, input logic m2r, input logic mr, input logic mw,
                     input logic [1:0] sz, input logic uns);
    set_in(alu, sd, dest, rw, m2r, mr, mw, sz, uns);
    step();
    set_idle();
    step();
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
    run(addr, data, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, sz, 1'b0);
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] dest, input logic [1:0] sz,
                      input logic uns);
    run(addr, 32'h0, dest, 1'b1, 1'b1, 1'b1, 1'b0, sz, uns);
  endtask

  initial begin
    #1 i_reset = 1'b0;
    #2;
    chk("rst_wb_data", o_wb_data, 32'h0);
    chk("rst_wb_addr", {27'h0, o_wb_addr}, 32'h0);
    chk("rst_wb_en", {31'h0, o_wb_en}, 32'h0);
    chk("rst_fwd_data", o_fwd_data, 32'h0);
    chk("rst_fwd_en", {31'h0, o_fwd_en}, 32'h0);
    chk("rst_misaligned", {31'h0, o_misaligned}, 32'h0);
    step();
    i_reset = 1'b1;
    step();

    // SW then back-to-back LW to the same word
    set_in(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, SZ_W, 1'b0);
    step();
    set_in(32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, SZ_W, 1'b0);
    step();
    chk("sw_wb_en", {31'h0, o_wb_en}, 32'h0);
    set_idle();
    step();
    chk("lw_data", o_wb_data, 32'hDEADBEEF);
    chk("lw_addr", {27'h0, o_wb_addr}, 32'd5);
    chk("lw_en", {31'h0, o_wb_en}, 32'h1);
    chk("lw_misaligned", {31'h0, o_misaligned}, 32'h0);

    load(32'h1010, 5'd4, SZ_W, 1'b0);
    chk("lw_wrap", o_wb_data, 32'hDEADBEEF);

    // byte / half lanes on word 8
    store(32'h20, 32'h11223344, SZ_W);
    store(32'h21, 32'h00000080, SZ_B);
    load(32'h20, 5'd1, SZ_W, 1'b0);
    chk("sb_word", o_wb_data, 32'h11803344);
    load(32'h21, 5'd1, SZ_B, 1'b0);
    chk("lb", o_wb_data, 32'hFFFFFF80);
    load(32'h21, 5'd1, SZ_B, 1'b1);
    chk("lbu", o_wb_data, 32'h00000080);
    store(32'h22, 32'h0000ABCD, SZ_H);
    load(32'h22, 5'd1, SZ_H, 1'b0);
    chk("lh_neg", o_wb_data, 32'hFFFFABCD);
    load(32'h22, 5'd1, SZ_H, 1'b1);
    chk("lhu", o_wb_data, 32'h0000ABCD);
    load(32'h20, 5'd1, SZ_H, 1'b0);
    chk("lh_pos", o_wb_data, 32'h00001180);
    load(32'h23, 5'd1, SZ_B, 1'b0);
    chk("lb_off3", o_wb_data, 32'hFFFFFFCD);
    load(32'h20, 5'd1, SZ_B, 1'b1);
    chk("lbu_off0", o_wb_data, 32'h00000011);

    // alignment faults
    load(32'h12, 5'd6, SZ_W, 1'b0);
    chk("mis_lw_flag", {31'h0, o_misaligned}, 32'h1);
    chk("mis_lw_en", {31'h0, o_wb_en}, 32'h0);
    chk("mis_lw_data", o_wb_data, 32'h0);
    step();
    chk("mis_single_cycle", {31'h0, o_misaligned}, 32'h0);
    store(32'h13, 32'h0000FFFF, SZ_H);
    chk("mis_sh_flag", {31'h0, o_misaligned}, 32'h1);
    load(32'h10, 5'd5, SZ_W, 1'b0);
    chk("mis_sh_nowrite", o_wb_data, 32'hDEADBEEF);
    load(32'h21, 5'd6, SZ_H, 1'b0);
    chk("mis_lh_flag", {31'h0, o_misaligned}, 32'h1);

    // flushed store
    set_in(32'h10, 32'h55555555, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, SZ_W, 1'b0);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("flush_fwd_en", {31'h0, o_fwd_en}, 32'h0);
    set_idle();
    step();
    chk("flush_wb_en", {31'h0, o_wb_en}, 32'h0);
    load(32'h10, 5'd5, SZ_W, 1'b0);
    chk("flush_nowrite", o_wb_data, 32'hDEADBEEF);

    // stalled store behind a load
    set_in(32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, SZ_W, 1'b0);
    step();
    set_in(32'h14, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, SZ_W, 1'b0);
    step();
    set_idle();
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_wb_data", o_wb_data, 32'hDEADBEEF);
      chk("stall_wb_en", {31'h0, o_wb_en}, 32'h1);
      chk("stall_fwd_data", o_fwd_data, 32'h14);
    end
    i_stall = 1'b0;
    step();
    chk("unstall_wb_en", {31'h0, o_wb_en}, 32'h0);
    load(32'h14, 5'd2, SZ_W, 1'b0);
    chk("stall_store_lands", o_wb_data, 32'hCAFEF00D);

    // read+write together acts as a store
    run(32'h18, 32'h01020304, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, SZ_W, 1'b0);
    chk("rw_both_en", {31'h0, o_wb_en}, 32'h0);
    load(32'h18, 5'd3, SZ_W, 1'b0);
    chk("rw_both_store", o_wb_data, 32'h01020304);

    // forwarding
    set_in(32'h1234, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, SZ_W, 1'b0);
    step();
    chk("fwd_en_add", {31'h0, o_fwd_en}, 32'h1);
    chk("fwd_data_add", o_fwd_data, 32'h1234);
    chk("fwd_addr_add", {27'h0, o_fwd_addr}, 32'd7);
    set_in(32'h1234, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, SZ_W, 1'b0);
    step();
    chk("fwd_en_load", {31'h0, o_fwd_en}, 32'h0);
    chk("add_wb_data", o_wb_data, 32'h1234);
    chk("add_wb_addr", {27'h0, o_wb_addr}, 32'd7);
    set_idle();
    step();

    // dest $0 never written
    run(32'h77, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, SZ_W, 1'b0);
    chk("dest0_en", {31'h0, o_wb_en}, 32'h0);

    // async reset while a store sits in EX/MEM
    set_in(32'h4321, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, SZ_W, 1'b0);
    step();
    set_in(32'h10, 32'h0BADF00D, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, SZ_W, 1'b0);
    step();
    chk("pre_rst_wb_data", o_wb_data, 32'h4321);
    set_idle();
    #2 i_reset = 1'b0;
    #1;
    chk("mid_rst_wb_data", o_wb_data, 32'h0);
    chk("mid_rst_wb_en", {31'h0, o_wb_en}, 32'h0);
    chk("mid_rst_fwd_data", o_fwd_data, 32'h0);
    step();
    i_reset = 1'b1;
    load(32'h10, 5'd5, SZ_W, 1'b0);
    chk("rst_abort_store", o_wb_data, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
